// File: rtl/aes_inv_mix_columns_engine.sv
// Byte-serial (In)MixColumns engine working on a 16-byte AES state in shared memory.
// Loads 16 bytes, mixes the four columns in place (one per cycle), then writes 16 bytes
// back. Fixed latency of 38 cycles from start to done.
// Optional build macro AES_FWD_MIX_COLUMNS_EN adds a fwd_mode input that selects the
// forward MixColumns transform; without it the engine is inverse-only.
module aes_inv_mix_columns_engine #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
`ifdef AES_FWD_MIX_COLUMNS_EN
    input  logic                  fwd_mode,
`endif
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [7:0]            mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [7:0]            mem_wr_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_STORE,
        S_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [4:0]            cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0] src_reg, dst_reg;
    logic                  cap_en_reg;
    logic [3:0]            cap_idx_reg;
    logic                  fwd_sel;
    logic [7:0]            state_buf_reg [16];
    logic [7:0]            col_byte [4];
    logic [7:0]            col_mix [4];

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One output row: a0 is the byte on the same row, a1..a3 the following rows (wrapping).
    // Inverse: 0e.a0 ^ 0b.a1 ^ 0d.a2 ^ 09.a3   Forward: 02.a0 ^ 03.a1 ^ a2 ^ a3
    function automatic logic [7:0] mix_row(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3,
                                           input logic fwd);
        logic [7:0] a0x2, a0x4, a0x8, a1x2, a1x4, a1x8, a2x2, a2x4, a2x8, a3x2, a3x4, a3x8;
        a0x2 = xtime(a0); a0x4 = xtime(a0x2); a0x8 = xtime(a0x4);
        a1x2 = xtime(a1); a1x4 = xtime(a1x2); a1x8 = xtime(a1x4);
        a2x2 = xtime(a2); a2x4 = xtime(a2x2); a2x8 = xtime(a2x4);
        a3x2 = xtime(a3); a3x4 = xtime(a3x2); a3x8 = xtime(a3x4);
        if (fwd)
            return a0x2 ^ a1x2 ^ a1 ^ a2 ^ a3;
        else
            return (a0x8 ^ a0x4 ^ a0x2) ^ (a1x8 ^ a1x2 ^ a1) ^
                   (a2x8 ^ a2x4 ^ a2) ^ (a3x8 ^ a3) ^ (a3x4 & 8'h00) ^ (a3x2 & 8'h00);
    endfunction

`ifdef AES_FWD_MIX_COLUMNS_EN
    logic fwd_reg;
    assign fwd_sel = fwd_reg;
`else
    assign fwd_sel = 1'b0;
`endif

    // Column currently being mixed is selected by the low counter bits during COMPUTE.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign col_byte[gi] = state_buf_reg[{cnt_reg[1:0], 2'(gi)}];
            assign col_mix[gi]  = mix_row(col_byte[gi], col_byte[(gi + 1) % 4],
                                          col_byte[(gi + 2) % 4], col_byte[(gi + 3) % 4],
                                          fwd_sel);
        end
    endgenerate

    // Control state, operation parameters and the read-capture pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            src_reg     <= '0;
            dst_reg     <= '0;
            cap_en_reg  <= 1'b0;
            cap_idx_reg <= '0;
`ifdef AES_FWD_MIX_COLUMNS_EN
            fwd_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cap_en_reg  <= mem_rd_en;
            cap_idx_reg <= cnt_reg[3:0];
            if (state_reg == S_IDLE && start) begin
                src_reg <= src_base;
                dst_reg <= dst_base;
`ifdef AES_FWD_MIX_COLUMNS_EN
                fwd_reg <= fwd_mode;
`endif
            end
        end
    end

    // State buffer: captures read data one cycle after each read, then mixes columns in place.
    always_ff @(posedge clk) begin
        if (cap_en_reg) begin
            state_buf_reg[cap_idx_reg] <= mem_rd_data;
        end else if (state_reg == S_COMPUTE) begin
            for (int r = 0; r < 4; r++)
                state_buf_reg[{cnt_reg[1:0], 2'(r)}] <= col_mix[r];
        end
    end

    // Next-state logic and memory/handshake outputs.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    cnt_next   = '0;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                // Count 16 issues reads; the extra count waits for the last capture.
                if (!cnt_reg[4]) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = src_reg + ADDR_WIDTH'(cnt_reg[3:0]);
                end
                if (cnt_reg == 5'd16) begin
                    state_next = S_COMPUTE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (cnt_reg == 5'd3) begin
                    state_next = S_STORE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            S_STORE: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_wr_addr = dst_reg + ADDR_WIDTH'(cnt_reg[3:0]);
                mem_wr_data = state_buf_reg[cnt_reg[3:0]];
                if (cnt_reg == 5'd15) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_inv_mix_columns_engine.sv
// Directed bench for aes_inv_mix_columns_engine with a byte-wide memory model that
// returns read data one cycle after the read strobe. Expected results are hand-computed.
module tb_aes_inv_mix_columns_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src_base, dst_base;
    logic        fwd_mode;
    logic        mem_rd_en, mem_wr_en, busy, done;
    logic [15:0] mem_rd_addr, mem_wr_addr;
    logic [7:0]  mem_rd_data, mem_wr_data;

    aes_inv_mix_columns_engine #(.ADDR_WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_base    (src_base),
        .dst_base    (dst_base),
`ifdef AES_FWD_MIX_COLUMNS_EN
        .fwd_mode    (fwd_mode),
`endif
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          failures = 0;

    int          cyc, rd_cnt, wr_cnt, done_cnt, done_cyc, busy_cnt;
    int          addr_bad, order_bad, overlap, first_rd_cyc, last_wr_cyc;
    logic        pend_rd;
    logic [15:0] pend_addr, cur_src, cur_dst;

    localparam logic [127:0] IN_T1  = 128'h8e4da1bc_01010101_01010101_01010101;
    localparam logic [127:0] OUT_T1 = 128'hdb135345_01010101_01010101_01010101;
    localparam logic [127:0] IN_T2  = 128'h9fdc589d_d5d5d7d6_4d7ebdf8_c6c6c6c6;
    localparam logic [127:0] OUT_T2 = 128'hf20a225c_d4d4d4d5_2d26314c_c6c6c6c6;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load16(input logic [15:0] base, input logic [127:0] bytes);
        logic [15:0] a;
        for (int i = 0; i < 16; i++) begin
            a = base + 16'(i);
            mem[a] = bytes[127 - 8*i -: 8];
        end
    endtask

    function automatic logic [127:0] read16(input logic [15:0] base);
        logic [127:0] v;
        logic [15:0]  a;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            a = base + 16'(i);
            v[127 - 8*i -: 8] = mem[a];
        end
        return v;
    endfunction

    // Memory model and activity monitor, called once per falling edge.
    task automatic service();
        mem_rd_data = pend_rd ? mem[pend_addr] : 8'ha5;
        pend_rd     = mem_rd_en;
        pend_addr   = mem_rd_addr;
        if (mem_rd_en) begin
            if (mem_rd_addr !== cur_src + 16'(rd_cnt)) addr_bad++;
            if (rd_cnt == 0) first_rd_cyc = cyc;
            rd_cnt++;
        end
        if (mem_wr_en) begin
            if (mem_wr_addr !== cur_dst + 16'(wr_cnt)) addr_bad++;
            if (rd_cnt < 16) order_bad++;
            mem[mem_wr_addr] = mem_wr_data;
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (mem_rd_en && mem_wr_en) overlap++;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
    endtask

    // Runs one operation for a fixed 45-cycle window; p1/p2 are extra start pulses,
    // abort_at asserts reset mid-cycle. Must be entered right after a falling edge.
    task automatic run_op(input logic [15:0] src, input logic [15:0] dst,
                          input int p1, input int p2, input int abort_at, input logic fwd);
        cur_src = src; cur_dst = dst;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        addr_bad = 0; order_bad = 0; overlap = 0; first_rd_cyc = -1; last_wr_cyc = -1;
        src_base = src; dst_base = dst; fwd_mode = fwd;
        start = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            cyc = i;
            start = (i == p1 || i == p2);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
            end
            service();
            if (i == abort_at) begin
                check_eq("abort_wr_en", 128'(mem_wr_en), 128'd0);
                check_eq("abort_busy", 128'(busy), 128'd0);
                check_eq("abort_rd_en", 128'(mem_rd_en), 128'd0);
            end
        end
        start = 1'b0;
    endtask

    task automatic check_timing(input string tag);
        check_eq({tag, "_done_cyc"}, 128'(done_cyc), 128'd38);
        check_eq({tag, "_done_cnt"}, 128'(done_cnt), 128'd1);
        check_eq({tag, "_reads"}, 128'(rd_cnt), 128'd16);
        check_eq({tag, "_writes"}, 128'(wr_cnt), 128'd16);
        check_eq({tag, "_addr_bad"}, 128'(addr_bad), 128'd0);
        check_eq({tag, "_overlap"}, 128'(overlap), 128'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; fwd_mode = 1'b0;
        mem_rd_data = 8'h00; pend_rd = 1'b0; pend_addr = '0;
        cur_src = '0; cur_dst = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_strobes", {124'd0, mem_rd_en, mem_wr_en, busy, done}, 128'd0);
        check_eq("reset_addrs", {80'd0, mem_rd_addr, mem_wr_addr, mem_wr_data}, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: in place, one non-trivial column
        load16(16'h0100, IN_T1);
        run_op(16'h0100, 16'h0100, -1, -1, -1, 1'b0);
        check_eq("t1_result", read16(16'h0100), OUT_T1);
        check_timing("t1");
        check_eq("t1_first_rd", 128'(first_rd_cyc), 128'd1);
        check_eq("t1_last_wr", 128'(last_wr_cyc), 128'd37);
        check_eq("t1_busy_cycles", 128'(busy_cnt), 128'd37);
        $display("op1 src=0100 dst=0100 done_cyc=%0d reads=%0d writes=%0d", done_cyc, rd_cnt, wr_cnt);

        // 2: four distinct columns, separate destination
        load16(16'h0000, IN_T2);
        run_op(16'h0000, 16'h0040, -1, -1, -1, 1'b0);
        check_eq("t2_result", read16(16'h0040), OUT_T2);
        check_eq("t2_src_kept", read16(16'h0000), IN_T2);
        check_timing("t2");
        $display("op2 src=0000 dst=0040 done_cyc=%0d reads=%0d writes=%0d", done_cyc, rd_cnt, wr_cnt);

        // 3: wrap-around with overlapping source and destination
        load16(16'hfff8, IN_T2);
        run_op(16'hfff8, 16'hfffc, -1, -1, -1, 1'b0);
        check_eq("t3_result", read16(16'hfffc), OUT_T2);
        check_eq("t3_order_bad", 128'(order_bad), 128'd0);
        check_eq("t3_beyond_kept", 128'(mem[16'h000c]), 128'hc6);
        check_timing("t3");
        $display("op3 src=fff8 dst=fffc done_cyc=%0d reads=%0d writes=%0d", done_cyc, rd_cnt, wr_cnt);

        // 4: start pulses while busy are ignored
        load16(16'h0200, IN_T2);
        run_op(16'h0200, 16'h0300, 5, 30, -1, 1'b0);
        check_eq("t4_result", read16(16'h0300), OUT_T2);
        check_timing("t4");
        $display("op4 src=0200 dst=0300 extra starts@5,30 done_cnt=%0d reads=%0d writes=%0d", done_cnt, rd_cnt, wr_cnt);

        // 5: reset during STORE, then a clean rerun
        load16(16'h0400, IN_T1);
        load16(16'h0500, {16{8'hee}});
        run_op(16'h0400, 16'h0500, -1, -1, 25, 1'b0);
        check_eq("t5_writes", 128'(wr_cnt), 128'd3);
        check_eq("t5_done_cnt", 128'(done_cnt), 128'd0);
        check_eq("t5_partial", read16(16'h0500), {24'hdb1353, {13{8'hee}}});
        $display("op5 src=0400 dst=0500 reset@25 writes=%0d done_cnt=%0d", wr_cnt, done_cnt);
        reset = 1'b0;
        @(negedge clk);
        run_op(16'h0400, 16'h0500, -1, -1, -1, 1'b0);
        check_eq("t5_rerun_result", read16(16'h0500), OUT_T1);
        check_timing("t5_rerun");
        $display("op5b src=0400 dst=0500 done_cyc=%0d reads=%0d writes=%0d", done_cyc, rd_cnt, wr_cnt);

`ifdef AES_FWD_MIX_COLUMNS_EN
        // 6: forward then inverse round trip
        load16(16'h0600, OUT_T1);
        run_op(16'h0600, 16'h0700, -1, -1, -1, 1'b1);
        check_eq("t6_fwd_result", read16(16'h0700), IN_T1);
        check_timing("t6_fwd");
        $display("op6 fwd src=0600 dst=0700 done_cyc=%0d", done_cyc);
        run_op(16'h0700, 16'h0800, -1, -1, -1, 1'b0);
        check_eq("t6_inv_result", read16(16'h0800), OUT_T1);
        check_timing("t6_inv");
        $display("op6b inv src=0700 dst=0800 done_cyc=%0d", done_cyc);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
